// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and instruction memory (slave).
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC/IR ownership, imem read handshake, next-PC selection,
// misaligned-target trap and retired-instruction count.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RSTn,
    fetch_unit_if.master      imem,
    input  logic              PCWrite,
    input  logic              Jump,
    input  logic              Branch,
    input  logic              JALorJALR,
    input  logic              BrTaken,
    input  logic [31:0]       Imm,
    input  logic [31:0]       ALUResult,
    output logic [31:0]       IR,
    output logic [6:0]        opcode,
    output logic [2:0]        funct3,
    output logic              ir_valid,
    output logic [31:0]       PC,
    output logic [31:0]       PCPlus4,
    output logic              misalign,
    output logic [31:0]       retired
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        TRAP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   ir_q, ir_d;
    logic [XLEN-1:0]   retired_q, retired_d;
    logic              misalign_q, misalign_d;
    logic [XLEN-1:0]   next_pc_c;
    logic              req_c;
    logic              valid_c;

    // Next-PC source select; all sums wrap silently
    always_comb begin
        next_pc_c = pc_q + XLEN'(4);
        if (JALorJALR && Jump) begin
            next_pc_c = ALUResult & 32'hFFFF_FFFE;
        end else if (Jump) begin
            next_pc_c = pc_q + Imm;
        end else if (Branch && BrTaken) begin
            next_pc_c = pc_q + Imm;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= NOP;
            retired_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            retired_q  <= retired_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        retired_d  = retired_q;
        misalign_d = misalign_q;
        req_c      = 1'b0;
        valid_c    = 1'b0;

        case (state_q)
            FETCH, WAIT: begin
                req_c = 1'b1;
                if (imem.imem_ready) begin
                    ir_d    = imem.imem_rdata;
                    state_d = HOLD;
                end else begin
                    state_d = WAIT;
                end
            end
            HOLD: begin
                valid_c = 1'b1;
                if (PCWrite) begin
                    // Bit 1 set means a non-word-aligned target: trap without committing
                    if (next_pc_c[1]) begin
                        misalign_d = 1'b1;
                        state_d    = TRAP;
                    end else begin
                        pc_d      = next_pc_c;
                        retired_d = retired_q + XLEN'(1);
                        state_d   = FETCH;
                    end
                end
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Reset masks the handshake outputs immediately, not just after the edge
        if (!RSTn) begin
            req_c   = 1'b0;
            valid_c = 1'b0;
        end
    end

    assign imem.imem_req  = req_c;
    assign imem.imem_addr = pc_q;
    assign ir_valid       = valid_c;
    assign IR             = ir_q;
    assign opcode         = ir_q[6:0];
    assign funct3         = ir_q[14:12];
    assign PC             = pc_q;
    assign PCPlus4        = pc_q + XLEN'(4);
    assign misalign       = misalign_q;
    assign retired        = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: IR scoreboard fed at the memory-ready cycle,
// reference next-PC model, handshake/timing/trap/reset checks.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        PCWrite, Jump, Branch, JALorJALR, BrTaken;
    logic [31:0] Imm, ALUResult;
    logic [31:0] IR, PC, PCPlus4, retired;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        ir_valid, misalign;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .imem      (bus),
        .PCWrite   (PCWrite),
        .Jump      (Jump),
        .Branch    (Branch),
        .JALorJALR (JALorJALR),
        .BrTaken   (BrTaken),
        .Imm       (Imm),
        .ALUResult (ALUResult),
        .IR        (IR),
        .opcode    (opcode),
        .funct3    (funct3),
        .ir_valid  (ir_valid),
        .PC        (PC),
        .PCPlus4   (PCPlus4),
        .misalign  (misalign),
        .retired   (retired)
    );

    always #5 CLK = ~CLK;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [31:0] exp_ir_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    logic [31:0] exp_ir;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Fetch at exp_pc with a given number of not-ready cycles, then check IR via scoreboard
    task automatic do_fetch(input int waits, input logic [31:0] data);
        logic [31:0] got;
        for (int i = 0; i < waits; i++) begin
            bus.imem_ready = 1'b0;
            bus.imem_rdata = $urandom;
            #1;
            check("req_pending", 32'(bus.imem_req), 32'd1);
            check("addr_stable", bus.imem_addr, exp_pc);
            tick();
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = data;
        exp_ir_q.push_back(data);
        #1;
        check("addr_ready", bus.imem_addr, exp_pc);
        tick();
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'hA5A5_A5A5;
        check("ir_valid_hold", 32'(ir_valid), 32'd1);
        check("req_hold", 32'(bus.imem_req), 32'd0);
        if (exp_ir_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            got = exp_ir_q.pop_front();
            check("ir", IR, got);
            exp_ir = got;
        end
    endtask

    // One HOLD-cycle commit with a reference-model next PC
    task automatic commit(input string tag, input logic jmp, input logic br, input logic jal,
                          input logic tkn, input logic [31:0] imm, input logic [31:0] alu);
        logic [31:0] npc;
        if (jal && jmp)       npc = {alu[31:1], 1'b0};
        else if (jmp)         npc = exp_pc + imm;
        else if (br && tkn)   npc = exp_pc + imm;
        else                  npc = exp_pc + 32'd4;
        Jump = jmp; Branch = br; JALorJALR = jal; BrTaken = tkn;
        Imm = imm; ALUResult = alu; PCWrite = 1'b1;
        tick();
        PCWrite = 1'b0; Jump = 1'b0; Branch = 1'b0; JALorJALR = 1'b0; BrTaken = 1'b0;
        if (npc[1] == 1'b0) begin
            exp_pc  = npc;
            exp_ret = exp_ret + 32'd1;
            check({tag, "_req"}, 32'(bus.imem_req), 32'd1);
            check({tag, "_addr"}, bus.imem_addr, exp_pc);
        end
        check({tag, "_pc"}, PC, exp_pc);
        check({tag, "_retired"}, retired, exp_ret);
    endtask

    initial begin
        RSTn = 1'b0; PCWrite = 1'b0; Jump = 1'b0; Branch = 1'b0; JALorJALR = 1'b0;
        BrTaken = 1'b0; Imm = '0; ALUResult = '0;
        bus.imem_ready = 1'b0; bus.imem_rdata = '0;
        exp_pc = RESET_PC; exp_ret = '0; exp_ir = NOP;

        tick(); tick();
        check("rst_ir", IR, NOP);
        check("rst_pc", PC, RESET_PC);
        check("rst_retired", retired, 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_valid", 32'(ir_valid), 32'd0);

        // Zero-wait fetch: request in first released cycle, ir_valid in the second
        RSTn = 1'b1;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h0050_0093;
        #1;
        check("first_req", 32'(bus.imem_req), 32'd1);
        check("first_valid", 32'(ir_valid), 32'd0);
        do_fetch(0, 32'h0050_0093);
        check("opcode", 32'(opcode), 32'h13);
        check("funct3", 32'(funct3), 32'd0);
        check("pc0", PC, 32'd0);
        check("pcplus4", PCPlus4, 32'd4);

        // HOLD ignores imem_ready and keeps IR/PC while PCWrite is low
        bus.imem_ready = 1'b1; bus.imem_rdata = 32'hFFFF_FFFF;
        tick(); tick();
        bus.imem_ready = 1'b0;
        check("hold_ir", IR, exp_ir);
        check("hold_pc", PC, exp_pc);
        check("hold_valid", 32'(ir_valid), 32'd1);

        commit("seq", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        do_fetch(3, 32'h0020_8133);
        check("funct3_w", 32'(funct3), 32'd0);
        check("opcode_w", 32'(opcode), 32'h33);

        commit("jal", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_000C, 32'hDEAD_0000);
        do_fetch(1, 32'hFE00_0CE3);
        check("pc10", PC, 32'h10);
        check("funct3_b", 32'(funct3), 32'd0);

        commit("br_taken", 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'd0);
        check("br_pc8", PC, 32'h08);
        do_fetch(2, 32'h0000_4063);
        check("funct3_4", 32'(funct3), 32'd4);

        commit("br_not", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'd0);
        do_fetch(0, 32'h0000_8067);

        commit("jalr", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0105);
        check("jalr_pc", PC, 32'h104);
        do_fetch(0, 32'h0000_8067);

        commit("jalr_hi", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFD);
        do_fetch(1, NOP);
        commit("wrap", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("wrap_pc", PC, 32'd0);
        do_fetch(0, 32'h0060_006F);

        // Misaligned jump target traps without committing
        commit("mis", 1'b1, 1'b0, 1'b0, 1'b0, 32'd6, 32'd0);
        check("mis_flag", 32'(misalign), 32'd1);
        check("mis_req", 32'(bus.imem_req), 32'd0);
        check("mis_valid", 32'(ir_valid), 32'd0);
        bus.imem_ready = 1'b1; bus.imem_rdata = 32'h1234_5678; PCWrite = 1'b1;
        tick(); tick(); tick();
        PCWrite = 1'b0; bus.imem_ready = 1'b0;
        check("trap_req", 32'(bus.imem_req), 32'd0);
        check("trap_pc", PC, 32'd0);
        check("trap_ir", IR, exp_ir);
        check("trap_retired", retired, exp_ret);
        check("trap_flag", 32'(misalign), 32'd1);

        // Reset out of TRAP, then reset abandoning a fetch in WAIT
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        exp_pc = RESET_PC; exp_ret = '0;
        check("trap_rst_misalign", 32'(misalign), 32'd0);
        tick();
        check("wait_req", 32'(bus.imem_req), 32'd1);
        RSTn = 1'b0;
        bus.imem_ready = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("rst_wait_req", 32'(bus.imem_req), 32'd0);
        tick();
        bus.imem_ready = 1'b0;
        check("rst_wait_ir", IR, NOP);
        check("rst_wait_pc", PC, RESET_PC);
        check("rst_wait_retired", retired, 32'd0);
        RSTn = 1'b1;
        #1;
        check("rel_req", 32'(bus.imem_req), 32'd1);
        do_fetch(1, 32'h0010_0113);
        check("scoreboard_drained", 32'(exp_ir_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
